// File: rtl/i2s_tx.sv
// I2S transmitter: decimates a 100 MHz mono stream to one sample per frame and
// serialises it as Philips I2S (32-bit slots, mono duplicated on L/R) with MCLK/BCLK/LRCK.
module i2s_tx #(
    parameter int unsigned MCLK_DIV_LOG2 = 3,
    parameter bit          OFFSET_BINARY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_active_low,
    input  logic        enable,
    input  logic        mute,
    input  logic [15:0] sample_in,
    output logic        sample_req,
    output logic        mclk,
    output logic        bclk,
    output logic        lrck,
    output logic        sdata
);

    localparam int unsigned W       = MCLK_DIV_LOG2 + 8;
    localparam int unsigned BidxLsb = MCLK_DIV_LOG2 + 2;

    logic [W-1:0] cnt_q, cnt_d;
    logic [63:0]  sr_q, sr_d;
    logic         frame_end;
    logic         bclk_fall;
    logic [15:0]  s;

    // frame_end: next edge wraps cnt to 0; bclk_fall: next edge drives bclk low
    assign frame_end = &cnt_q;
    assign bclk_fall = &cnt_q[BidxLsb-1:0];

    always_comb begin
        s = sample_in;
        if (mute) begin
            s = 16'h0000;
        end else if (OFFSET_BINARY) begin
            s = sample_in ^ 16'h8000;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (!enable) begin
            cnt_d = '0;
            sr_d  = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
            if (frame_end) begin
                // Leading zero in each slot is the one-BCLK I2S delay bit
                sr_d = {1'b0, s, 15'b0, 1'b0, s, 15'b0};
            end else if (bclk_fall) begin
                sr_d = {sr_q[62:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    // Clocks come straight from counter flops so they cannot glitch
    assign mclk       = cnt_q[MCLK_DIV_LOG2-1];
    assign bclk       = cnt_q[MCLK_DIV_LOG2+1];
    assign lrck       = cnt_q[W-1];
    assign sdata      = sr_q[63];
    assign sample_req = enable & frame_end;

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
- Downstream output stage of the player: consumes the 16-bit offset-binary mono `output_stream` produced by the phrase playback block at 100 MHz.
- Decimates it to one sample per audio frame and converts it to two's complement.
- Serialises it as standard I2S (Philips, 1-BCLK MSB delay, 32-bit slots) for an external DAC (CS4344-class).
- Generates MCLK/BCLK/LRCK from a single free-running divider; the mono sample is duplicated on left and right.

Parameters:
- MCLK_DIV_LOG2, 3, MCLK = clk / 2^MCLK_DIV_LOG2 (100 MHz -> 12.5 MHz); BCLK = MCLK/4; LRCK = BCLK/64 (fs = 48.828 kHz at default).
- OFFSET_BINARY, 1, 1 = sample_in is offset binary (16'h8000 = silence), MSB inverted on capture; 0 = already two's complement, passed unchanged.

Ports:
- clk  input  1  100 MHz system clock
- rst_active_low  input  1  asynchronous active-low reset
- enable  input  1  1 = divider runs and frames transmit; 0 = block held idle
- mute  input  1  1 = captured sample forced to 16'h0000 (two's complement zero)
- sample_in  input  16  audio sample from playback stage
- sample_req  output  1  one-clk pulse in the last clk of each frame; sample_in is captured on the following edge
- mclk  output  1  DAC master clock
- bclk  output  1  I2S bit clock
- lrck  output  1  I2S word select, 0 = left
- sdata  output  1  I2S serial data

Behaviour:
- Reset is asynchronous, active-low, and clears every register at any time, including mid-frame. After reset, all outputs are 0, the counter is 0 and the shift register is 0.
- Counter:
  - cnt is W = MCLK_DIV_LOG2 + 8 bits wide (11 at default) and increments by 1 every clk while enable = 1, wrapping from all-ones to 0.
  - With enable = 0, cnt and the shift register are synchronously cleared, so all outputs are 0 on the next edge.
- Clock outputs are taken directly from register bits, so they are glitch-free:
  - mclk = cnt[MCLK_DIV_LOG2-1]
  - bclk = cnt[MCLK_DIV_LOG2+1]
  - lrck = cnt[W-1]
  - At default: mclk period 8 clk, bclk period 32 clk, lrck period 2048 clk.
- Bit index: bidx = cnt[W-1 : MCLK_DIV_LOG2+2] (0..63). A BCLK falling edge is the clk edge on which cnt[MCLK_DIV_LOG2+1:0] wraps from all-ones to 0.
- Shift register sr[63:0] with sdata = sr[63]:
  - On the edge where cnt wraps from all-ones to 0 (frame boundary), sr loads {1'b0, s, 15'b0, 1'b0, s, 15'b0}.
  - On every other BCLK falling edge, sr shifts left by 1 with 0 fill.
  - sdata and lrck therefore change on the same clk edge that drives bclk low; the DAC samples on bclk rising.
- Slot layout within each 32-bit slot:
  - bidx 0 / 32 = 0 (I2S delay bit).
  - bidx 1..16 / 33..48 = s[15..0].
  - bidx 17..31 / 49..63 = 0.
- Sample capture:
  - s is computed from sample_in on the frame-boundary edge: mute ? 16'h0000 : (OFFSET_BINARY ? sample_in ^ 16'h8000 : sample_in).
  - sample_req = 1 exactly while cnt == all-ones and enable = 1.
  - Changes to sample_in at any other time do not affect the frame in flight.
  - Latency from capture edge to sdata MSB = 32 clk (one BCLK); the right-channel MSB follows 1024 clk after the left MSB.
- Enable behaviour:
  - On enable rising, the first frame starts at cnt = 0 with sr = 0, so the first frame is all zeros.
  - The first real sample is captured at the end of that frame.
  - Deasserting enable mid-frame aborts the frame on the next edge (no partial completion).
- mute only takes effect at a frame boundary; asserting it mid-frame leaves the current frame unchanged.

Test Plan:
1. Reset and clock timing: rst_active_low = 0 -> all outputs 0. Release with enable = 1 -> mclk toggles every 4 clk, bclk every 16 clk, lrck every 1024 clk; the first frame's sdata is all 0.
2. Silence mapping: sample_in = 16'h8000 held -> from the second frame onward, sdata = 0 for all 64 bits.
3. Data format: sample_in = 16'hC000 -> left slot bidx1 = 0, bidx2 = 1, all other bits 0, and the same pattern at bidx33/34. sample_in = 16'h0000 -> bidx1 = 1 and bidx33 = 1 (value 16'h8000). Check that sdata changes only on bclk falling edges, in the same clk as lrck changes.
4. Capture timing: sample_req pulses for one clk every 2048 clk. Changing sample_in from 16'h8001 to 16'hFFFF 10 clk after the capture edge -> the current frame still carries 16'h0001, and the next frame carries 16'h7FFF.
5. Mute: mute = 1 with sample_in = 16'hFFFF, asserted mid-frame -> the current frame finishes with 16'h7FFF, and the next frame is all zeros.
6. Abort and recovery:
   - enable dropped at bidx 20 -> outputs are 0 on the next edge; re-enable -> a zero frame is sent, then the sample.
   - rst_active_low pulsed asynchronously mid-frame -> immediate all-zero outputs, and the identical restart sequence follows.
